// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   XLEN      : datapath / address width
//   NOP_INSTR : instruction presented to decode when nothing is valid
//   PC_STEP   : sequential fetch increment (one 32-bit word)
package if_stage_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [XLEN-1:0] PC_STEP = 32'd4;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/if_stage_fetch_buffer.sv
// fetch_buffer: 2-entry FIFO of {pc, instr} between instruction memory and decode.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_entry at the tail
//   pop        : remove the head entry
//   flush      : empty the FIFO (wins over push/pop)
//   push_entry : entry to write
//   count      : current occupancy (0..2)
//   head       : entry at the head (meaningful only when count != 0)
module fetch_buffer
   import if_stage_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t push_entry,
   output logic [1:0]   count,
   output fetch_entry_t head
);

   fetch_entry_t mem [2];
   logic         rd_ptr;
   logic         wr_ptr;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; count gates its visibility.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_entry;
   end

   always_comb begin
      head = mem[rd_ptr];
   end

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage. Holds the PC, issues word fetches over a
// valid/ready request port (in-order responses), buffers up to two returned
// instructions and hands them to decode with their PCs. Redirects reload the
// PC, flush the buffer and discard responses of requests already in flight.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   imem_req_valid/ready/addr       : fetch request port (word-aligned address)
//   imem_rsp_valid/data             : in-order fetch response
//   redirect_valid/pc               : load new PC, flush fetched and in-flight work
//   id_valid/ready                  : decode handshake
//   id_instruction/id_pc            : buffer head (NOP / 0 when id_valid = 0)
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_instruction,
   output logic [XLEN-1:0] id_pc
);

   logic [XLEN-1:0] fetch_pc;
   logic [1:0]      inflight;
   logic [1:0]      drop_cnt;
   logic [1:0]      buf_count;
   logic [XLEN-1:0] pcq [2];
   logic            pcq_rd;
   logic            pcq_wr;

   logic [2:0]      occ_sum;
   logic            occ_full;
   logic            pop;
   logic            accept;
   logic            rsp_take;
   logic            push;
   logic [1:0]      inflight_after_rsp;
   fetch_entry_t    push_entry;
   fetch_entry_t    head;

   always_comb begin
      occ_sum            = {1'b0, inflight} + {1'b0, buf_count};
      occ_full           = (occ_sum >= 3'd2);
      id_valid           = (buf_count != 2'd0);
      pop                = id_valid && id_ready;
      // A full slot may be reused in the cycle the head leaves (id_ready path).
      imem_req_valid     = !rst && !redirect_valid && (!occ_full || pop);
      imem_req_addr      = fetch_pc;
      accept             = imem_req_valid && imem_req_ready;
      rsp_take           = imem_rsp_valid && (inflight != 2'd0);
      push               = rsp_take && (drop_cnt == 2'd0) && !redirect_valid;
      inflight_after_rsp = inflight - {1'b0, rsp_take};
      push_entry.pc      = pcq[pcq_rd];
      push_entry.instr   = imem_rsp_data;
      id_instruction     = id_valid ? head.instr : NOP_INSTR;
      id_pc              = id_valid ? head.pc : '0;
   end

   fetch_buffer u_fetch_buffer (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .pop        (pop && !redirect_valid),
      .flush      (redirect_valid),
      .push_entry (push_entry),
      .count      (buf_count),
      .head       (head)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         inflight <= '0;
         drop_cnt <= '0;
         pcq_rd   <= 1'b0;
         pcq_wr   <= 1'b0;
      end else begin
         inflight <= inflight_after_rsp + {1'b0, accept};
         // Dropped responses still consume their PC-queue slot.
         if (accept)   pcq_wr <= ~pcq_wr;
         if (rsp_take) pcq_rd <= ~pcq_rd;
         if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~32'h0000_0003;
            // Every request still unreturned after this cycle is now stale.
            drop_cnt <= inflight_after_rsp;
         end else begin
            if (accept) fetch_pc <= fetch_pc + PC_STEP;
            if (rsp_take && (drop_cnt != 2'd0)) drop_cnt <= drop_cnt - 2'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) pcq[pcq_wr] <= fetch_pc;
   end

   always_ff @(posedge clk) begin
      if (!rst) assert (occ_sum <= 3'd2);
   end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage. A behavioural memory (in-order queue with
// per-request latency) feeds two DUTs sharing all inputs (RESET_PC = 0 and
// RESET_PC = FFFF_FFF8). The reference model tracks, per request, the redirect
// generation it belongs to and predicts handshakes and the PC/instruction
// stream decode must see.
module tb_if_stage;

   localparam logic [31:0] RST0 = 32'h0000_0000;
   localparam logic [31:0] RST1 = 32'hFFFF_FFF8;
   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] KEY  = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_ready;

   logic        req_valid0, req_valid1;
   logic [31:0] req_addr0, req_addr1;
   logic        id_valid0, id_valid1;
   logic [31:0] id_instr0, id_instr1;
   logic [31:0] id_pc0, id_pc1;

   always #5 clk = ~clk;

   if_stage #(.RESET_PC(RST0)) u_dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(req_valid0), .imem_req_ready(imem_req_ready), .imem_req_addr(req_addr0),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_valid(id_valid0), .id_ready(id_ready),
      .id_instruction(id_instr0), .id_pc(id_pc0)
   );

   if_stage #(.RESET_PC(RST1)) u_dut_hi (
      .clk(clk), .rst(rst),
      .imem_req_valid(req_valid1), .imem_req_ready(imem_req_ready), .imem_req_addr(req_addr1),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_valid(id_valid1), .id_ready(id_ready),
      .id_instruction(id_instr1), .id_pc(id_pc1)
   );

   typedef struct {
      logic [31:0] addr;
      int unsigned due;
      int unsigned gen;
   } mreq_t;

   mreq_t       mq[$];
   logic [31:0] popped[$];
   logic [31:0] hi_acc[$];
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   int unsigned cyc, gen, buffered, pops, lat_min, lat_max;
   logic [31:0] exp_fetch, exp_pc, exp_fetch1, exp_pc1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      id_ready       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      mq.delete();
      @(negedge clk);
      check("rst_req_valid", 32'(req_valid0), 32'd0);
      check("rst_req_valid_hi", 32'(req_valid1), 32'd0);
      @(posedge clk);
      #1;
      rst        = 1'b0;
      buffered   = 0;
      gen++;
      exp_fetch  = RST0;
      exp_pc     = RST0;
      exp_fetch1 = RST1;
      exp_pc1    = RST1;
      cyc        = 1;
   endtask

   // One clock cycle: drive inputs, predict and check at the negedge, advance model.
   task automatic tick(input logic idr, input logic redir, input logic [31:0] rpc, input logic mrdy);
      logic        rsp, pop, exp_rv;
      int unsigned occ;
      logic [31:0] tgt;
      mreq_t       h, n;
      id_ready       = idr;
      redirect_valid = redir;
      redirect_pc    = rpc;
      imem_req_ready = mrdy;
      rsp = 1'b0;
      if (mq.size() > 0) rsp = (mq[0].due <= cyc);
      imem_rsp_valid = rsp;
      imem_rsp_data  = rsp ? (mq[0].addr ^ KEY) : $urandom();
      @(negedge clk);
      occ    = mq.size() + buffered;
      pop    = (buffered > 0) && idr;
      exp_rv = !redir && ((occ < 2) || pop);
      check("id_valid", 32'(id_valid0), 32'(buffered > 0));
      check("id_valid_hi", 32'(id_valid1), 32'(buffered > 0));
      check("req_valid", 32'(req_valid0), 32'(exp_rv));
      check("req_valid_hi", 32'(req_valid1), 32'(exp_rv));
      if (buffered == 0) begin
         check("idle_instr", id_instr0, NOP);
         check("idle_pc", id_pc0, 32'd0);
      end
      if (pop) begin
         check("id_pc", id_pc0, exp_pc);
         check("id_instr", id_instr0, exp_pc ^ KEY);
         check("id_pc_hi", id_pc1, exp_pc1);
         popped.push_back(id_pc0);
         exp_pc  = exp_pc + 32'd4;
         exp_pc1 = exp_pc1 + 32'd4;
         pops++;
      end
      if (exp_rv) begin
         check("req_addr", req_addr0, exp_fetch);
         check("req_addr_hi", req_addr1, exp_fetch1);
      end
      if (rsp) begin
         h = mq.pop_front();
         if (h.gen == gen && !redir) buffered++;
      end
      if (pop) buffered--;
      if (exp_rv && mrdy) begin
         n.addr = exp_fetch;
         n.due  = cyc + $urandom_range(lat_max, lat_min);
         n.gen  = gen;
         mq.push_back(n);
         if (hi_acc.size() < 3) hi_acc.push_back(req_addr1);
         exp_fetch  = exp_fetch + 32'd4;
         exp_fetch1 = exp_fetch1 + 32'd4;
      end
      if (redir) begin
         tgt        = {rpc[31:2], 2'b00};
         exp_fetch  = tgt;
         exp_fetch1 = tgt;
         exp_pc     = tgt;
         exp_pc1    = tgt;
         buffered   = 0;
         gen++;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      int unsigned r;
      rst = 1'b1;
      gen = 0;
      lat_min = 1;
      lat_max = 1;

      // Streaming with 1-cycle memory: PCs 0,4,8,12 on cycles 3..6.
      do_reset();
      pops = 0;
      popped.delete();
      repeat (6) tick(1'b1, 1'b0, '0, 1'b1);
      check("pops_by_cycle6", pops, 32'd4);
      check("seq_pc0", popped[0], 32'h0);
      check("seq_pc1", popped[1], 32'h4);
      check("seq_pc2", popped[2], 32'h8);
      check("seq_pc3", popped[3], 32'hC);
      check("hi_addr0", hi_acc[0], 32'hFFFF_FFF8);
      check("hi_addr1", hi_acc[1], 32'hFFFF_FFFC);
      check("hi_addr2", hi_acc[2], 32'h0000_0000);

      // Decode stalled for 5 cycles, then resumes.
      repeat (5) tick(1'b0, 1'b0, '0, 1'b1);
      repeat (8) tick(1'b1, 1'b0, '0, 1'b1);

      // 3-cycle memory, redirect with two requests in flight.
      lat_min = 3;
      lat_max = 3;
      tick(1'b1, 1'b1, 32'h0000_0200, 1'b1);
      tick(1'b1, 1'b0, '0, 1'b1);
      tick(1'b1, 1'b0, '0, 1'b1);
      tick(1'b1, 1'b1, 32'h0000_1002, 1'b1);
      popped.delete();
      repeat (12) tick(1'b1, 1'b0, '0, 1'b1);
      check("redir_pc0", popped[0], 32'h0000_1000);
      check("redir_pc1", popped[1], 32'h0000_1004);

      // Redirect coinciding with a response and a pop.
      lat_min = 1;
      lat_max = 1;
      repeat (6) tick(1'b1, 1'b0, '0, 1'b1);
      tick(1'b1, 1'b1, 32'h0000_3000, 1'b1);
      check("redir_same_cycle_empty", 32'(id_valid0), 32'd0);
      repeat (4) tick(1'b1, 1'b0, '0, 1'b1);

      // Reset with two instructions buffered.
      repeat (4) tick(1'b0, 1'b0, '0, 1'b1);
      check("two_buffered", 32'(id_valid0), 32'd1);
      do_reset();
      check("post_rst_valid", 32'(id_valid0), 32'd0);
      check("post_rst_instr", id_instr0, NOP);
      check("post_rst_pc", id_pc0, 32'd0);
      repeat (4) tick(1'b1, 1'b0, '0, 1'b1);

      // Randomized traffic: variable latency, stalls, redirects, rare resets.
      lat_min = 1;
      lat_max = 4;
      repeat (2000) begin
         r = $urandom_range(199, 0);
         if (r == 0) do_reset();
         else tick($urandom_range(9, 0) < 7, r < 10, $urandom(), $urandom_range(9, 0) < 7);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
